// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - 7-segment scan bus readback decoder; optional macro SEGDEC_ORDER_CHECK_EN
module seg_scan_decoder #(
    parameter int DIGITS        = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DIGITS-1:0]     sel_n,
    input  logic [7:0]            seg_n,
    output logic [4*DIGITS-1:0]   digit_bcd,
    output logic [DIGITS-1:0]     digit_valid,
    output logic [DIGITS-1:0]     dp,
    output logic                  frame_done,
    output logic [15:0]           frame_cnt,
    output logic                  sel_err,
    output logic                  seg_err,
    output logic                  order_err
);

    typedef enum logic {S_WAIT, S_HELD} state_t;

    logic [DIGITS-1:0]   sel_q;
    logic [7:0]          seg_q;
    logic [3:0]          stab_q;
    state_t              state_q, state_d;
    logic [DIGITS-1:0]   mask_q;
    logic [4*DIGITS-1:0] bcd_q;
    logic [DIGITS-1:0]   valid_q, dp_q;
    logic [15:0]         fcnt_q;
    logic                frame_q, sel_err_q, seg_err_q;

    logic                changed, do_act, do_sample, do_selerr;
    logic [DIGITS-1:0]   sel_act;
    logic                blank, onehot, legal;
    logic [3:0]          value;

    // Map an active-low gfedcba pattern to its decimal value; bit 4 flags a legal digit.
    function automatic logic [4:0] decode7(input logic [6:0] p);
        case (p)
            7'h40:   decode7 = {1'b1, 4'd0};
            7'h79:   decode7 = {1'b1, 4'd1};
            7'h24:   decode7 = {1'b1, 4'd2};
            7'h30:   decode7 = {1'b1, 4'd3};
            7'h19:   decode7 = {1'b1, 4'd4};
            7'h12:   decode7 = {1'b1, 4'd5};
            7'h02:   decode7 = {1'b1, 4'd6};
            7'h78:   decode7 = {1'b1, 4'd7};
            7'h00:   decode7 = {1'b1, 4'd8};
            7'h10:   decode7 = {1'b1, 4'd9};
            default: decode7 = {1'b0, 4'hF};
        endcase
    endfunction

    assign changed = ({sel_n, seg_n} != {sel_q, seg_q});
    assign sel_act = ~sel_q;
    assign blank   = (sel_act == '0);
    assign onehot  = !blank && ((sel_act & (sel_act - 1'b1)) == '0);
    assign {legal, value} = decode7(seg_q[6:0]);

    // Input capture and saturating stability counter; any bus change restarts the settle window.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q  <= '1;
            seg_q  <= 8'hFF;
            stab_q <= 4'd0;
        end else begin
            sel_q  <= sel_n;
            seg_q  <= seg_n;
            if (changed)
                stab_q <= 4'd0;
            else if (stab_q != 4'hF)
                stab_q <= stab_q + 4'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_WAIT;
        else       state_q <= state_d;
    end

    // One action per stable dwell: WAIT acts once settled, HELD waits for the bus to move.
    always_comb begin
        state_d = state_q;
        do_act  = 1'b0;
        case (state_q)
            S_WAIT: begin
                if (stab_q >= 4'(SETTLE_CYCLES)) begin
                    do_act  = 1'b1;
                    state_d = changed ? S_WAIT : S_HELD;
                end
            end
            S_HELD: begin
                if (changed) state_d = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

    assign do_sample = do_act && onehot;
    assign do_selerr = do_act && !onehot && !blank;

    // Digit store, seen-mask, frame counter and error pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            bcd_q     <= '1;
            valid_q   <= '0;
            dp_q      <= '0;
            mask_q    <= '0;
            fcnt_q    <= 16'd0;
            frame_q   <= 1'b0;
            sel_err_q <= 1'b0;
            seg_err_q <= 1'b0;
        end else begin
            sel_err_q <= do_selerr;
            seg_err_q <= do_sample && !legal;
            frame_q   <= &mask_q;
            if (&mask_q)
                fcnt_q <= fcnt_q + 16'd1;
            mask_q <= ((&mask_q) ? '0 : mask_q) | (do_sample ? sel_act : '0);
            for (int i = 0; i < DIGITS; i++) begin
                if (do_sample && sel_act[i]) begin
                    bcd_q[4*i +: 4] <= legal ? value : 4'hF;
                    valid_q[i]      <= legal;
                    dp_q[i]         <= ~seg_q[7];
                end
            end
        end
    end

`ifdef SEGDEC_ORDER_CHECK_EN
    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [IDXW-1:0] idx, prev_q, expect_idx;
    logic            first_q, order_q;

    // Encode the one-hot select into a position index.
    always_comb begin
        idx = '0;
        for (int i = 0; i < DIGITS; i++)
            if (sel_act[i]) idx = IDXW'(i);
    end

    assign expect_idx = (prev_q == IDXW'(DIGITS-1)) ? '0 : prev_q + 1'b1;

    // Scan-order tracker; the first sample after reset is taken as the sequence start.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q  <= IDXW'(DIGITS-1);
            first_q <= 1'b1;
            order_q <= 1'b0;
        end else begin
            order_q <= do_sample && !first_q && (idx != expect_idx);
            if (do_sample) begin
                prev_q  <= idx;
                first_q <= 1'b0;
            end
        end
    end

    assign order_err = order_q;
`else
    assign order_err = 1'b0;
`endif

    assign digit_bcd   = bcd_q;
    assign digit_valid = valid_q;
    assign dp          = dp_q;
    assign frame_done  = frame_q;
    assign frame_cnt   = fcnt_q;
    assign sel_err     = sel_err_q;
    assign seg_err     = seg_err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - table-driven bench for seg_scan_decoder
module tb_seg_scan_decoder;

`ifdef SEGDEC_ORDER_CHECK_EN
    localparam int ORD = 1;
`else
    localparam int ORD = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  sel_n = 8'hFF;
    logic [7:0]  seg_n = 8'hFF;
    logic [31:0] digit_bcd;
    logic [7:0]  digit_valid, dp;
    logic        frame_done, sel_err, seg_err, order_err;
    logic [15:0] frame_cnt;

    seg_scan_decoder #(.DIGITS(8), .SETTLE_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .sel_n(sel_n), .seg_n(seg_n),
        .digit_bcd(digit_bcd), .digit_valid(digit_valid), .dp(dp),
        .frame_done(frame_done), .frame_cnt(frame_cnt),
        .sel_err(sel_err), .seg_err(seg_err), .order_err(order_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int c_sel = 0, c_seg = 0, c_frm = 0, c_ord = 0;

    // Pulse counters, sampled shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        if (sel_err)    c_sel++;
        if (seg_err)    c_seg++;
        if (frame_done) c_frm++;
        if (order_err)  c_ord++;
    end

    typedef struct {
        logic        rst;
        logic [7:0]  sel;
        logic [7:0]  seg;
        logic [31:0] bcd;
        logic [7:0]  val;
        logic [7:0]  dpx;
        logic [15:0] fc;
        int          d_sel, d_seg, d_frm, d_ord;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic r, input logic [7:0] s, input logic [7:0] g,
                       input logic [31:0] b, input logic [7:0] v, input logic [7:0] d,
                       input logic [15:0] f, input int ds, input int dg, input int df, input int dord);
        vec_t t;
        t.rst = r; t.sel = s; t.seg = g; t.bcd = b; t.val = v; t.dpx = d; t.fc = f;
        t.d_sel = ds; t.d_seg = dg; t.d_frm = df; t.d_ord = dord;
        tv.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_pulses(input string tag, input int s0, input int g0, input int f0, input int o0,
                                input int ds, input int dg, input int df, input int dord);
        check({tag, ".sel_err"},   32'(c_sel - s0), 32'(ds));
        check({tag, ".seg_err"},   32'(c_seg - g0), 32'(dg));
        check({tag, ".frame"},     32'(c_frm - f0), 32'(df));
        check({tag, ".order_err"}, 32'(c_ord - o0), 32'(dord));
    endtask

    task automatic run_row(input int k);
        int s0, g0, f0, o0;
        s0 = c_sel; g0 = c_seg; f0 = c_frm; o0 = c_ord;
        @(negedge clk);
        reset = tv[k].rst;
        sel_n = tv[k].sel;
        seg_n = tv[k].seg;
        repeat (4) @(negedge clk);
        check($sformatf("v%0d.bcd", k),   digit_bcd,          tv[k].bcd);
        check($sformatf("v%0d.valid", k), {24'd0, digit_valid}, {24'd0, tv[k].val});
        check($sformatf("v%0d.dp", k),    {24'd0, dp},          {24'd0, tv[k].dpx});
        check($sformatf("v%0d.fcnt", k),  {16'd0, frame_cnt},   {16'd0, tv[k].fc});
        check_pulses($sformatf("v%0d", k), s0, g0, f0, o0,
                     tv[k].d_sel, tv[k].d_seg, tv[k].d_frm, tv[k].d_ord);
    endtask

    int split;
    int s0, g0, f0, o0;

    initial begin
        // Table A: scan, select errors, illegal pattern, dp, repeats (state after latency test assumed)
        add(0, 8'hFE, 8'hF9, 32'hFFFFFFF1, 8'h01, 8'h00, 16'd0, 0, 0, 0, ORD);
        add(0, 8'hFD, 8'hA4, 32'hFFFFFF21, 8'h03, 8'h00, 16'd0, 0, 0, 0, 0);
        add(0, 8'hFB, 8'hB0, 32'hFFFFF321, 8'h07, 8'h00, 16'd0, 0, 0, 0, 0);
        add(0, 8'hF7, 8'h99, 32'hFFFF4321, 8'h0F, 8'h00, 16'd0, 0, 0, 0, 0);
        add(0, 8'hEF, 8'h92, 32'hFFF54321, 8'h1F, 8'h00, 16'd0, 0, 0, 0, 0);
        add(0, 8'hDF, 8'h82, 32'hFF654321, 8'h3F, 8'h00, 16'd0, 0, 0, 0, 0);
        add(0, 8'hBF, 8'hF8, 32'hF7654321, 8'h7F, 8'h00, 16'd0, 0, 0, 0, 0);
        add(0, 8'h7F, 8'h80, 32'h87654321, 8'hFF, 8'h00, 16'd0, 0, 0, 0, 0);
        add(0, 8'hFF, 8'hFF, 32'h87654321, 8'hFF, 8'h00, 16'd1, 0, 0, 1, 0);
        add(0, 8'hFC, 8'hFF, 32'h87654321, 8'hFF, 8'h00, 16'd1, 1, 0, 0, 0);
        add(0, 8'hFF, 8'hFF, 32'h87654321, 8'hFF, 8'h00, 16'd1, 0, 0, 0, 0);
        add(0, 8'hFB, 8'h7F, 32'h87654F21, 8'hFB, 8'h04, 16'd1, 0, 1, 0, ORD);
        add(0, 8'hFE, 8'h40, 32'h87654F20, 8'hFB, 8'h05, 16'd1, 0, 0, 0, ORD);
        add(0, 8'hFE, 8'h79, 32'h87654F21, 8'hFB, 8'h05, 16'd1, 0, 0, 0, ORD);
        split = tv.size();
        // Table B: reset, partial frame, reset mid-frame, full frame, order test
        add(1, 8'hFF, 8'hFF, 32'hFFFFFFFF, 8'h00, 8'h00, 16'd0, 0, 0, 0, 0);
        add(0, 8'hFE, 8'h90, 32'hFFFFFFF9, 8'h01, 8'h00, 16'd0, 0, 0, 0, 0);
        add(0, 8'hFD, 8'h90, 32'hFFFFFF99, 8'h03, 8'h00, 16'd0, 0, 0, 0, 0);
        add(0, 8'hFB, 8'h90, 32'hFFFFF999, 8'h07, 8'h00, 16'd0, 0, 0, 0, 0);
        add(0, 8'hF7, 8'h90, 32'hFFFF9999, 8'h0F, 8'h00, 16'd0, 0, 0, 0, 0);
        add(0, 8'hEF, 8'h90, 32'hFFF99999, 8'h1F, 8'h00, 16'd0, 0, 0, 0, 0);
        add(1, 8'hFF, 8'hFF, 32'hFFFFFFFF, 8'h00, 8'h00, 16'd0, 0, 0, 0, 0);
        add(0, 8'hFE, 8'h90, 32'hFFFFFFF9, 8'h01, 8'h00, 16'd0, 0, 0, 0, 0);
        add(0, 8'hFD, 8'h80, 32'hFFFFFF89, 8'h03, 8'h00, 16'd0, 0, 0, 0, 0);
        add(0, 8'hFB, 8'hF8, 32'hFFFFF789, 8'h07, 8'h00, 16'd0, 0, 0, 0, 0);
        add(0, 8'hF7, 8'h82, 32'hFFFF6789, 8'h0F, 8'h00, 16'd0, 0, 0, 0, 0);
        add(0, 8'hEF, 8'h92, 32'hFFF56789, 8'h1F, 8'h00, 16'd0, 0, 0, 0, 0);
        add(0, 8'hDF, 8'h99, 32'hFF456789, 8'h3F, 8'h00, 16'd0, 0, 0, 0, 0);
        add(0, 8'hBF, 8'hB0, 32'hF3456789, 8'h7F, 8'h00, 16'd0, 0, 0, 0, 0);
        add(0, 8'h7F, 8'hA4, 32'h23456789, 8'hFF, 8'h00, 16'd0, 0, 0, 0, 0);
        add(0, 8'hFF, 8'hFF, 32'h23456789, 8'hFF, 8'h00, 16'd1, 0, 0, 1, 0);
        add(0, 8'hFE, 8'hC0, 32'h23456780, 8'hFF, 8'h00, 16'd1, 0, 0, 0, 0);
        add(0, 8'hFD, 8'hF9, 32'h23456710, 8'hFF, 8'h00, 16'd1, 0, 0, 0, 0);
        add(0, 8'hF7, 8'h99, 32'h23454710, 8'hFF, 8'h00, 16'd1, 0, 0, 0, ORD);
        add(0, 8'hFF, 8'hFF, 32'h23454710, 8'hFF, 8'h00, 16'd1, 0, 0, 0, 0);

        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst.bcd",   digit_bcd, 32'hFFFFFFFF);
        check("rst.valid", {24'd0, digit_valid}, 32'd0);
        check("rst.dp",    {24'd0, dp}, 32'd0);
        check("rst.fcnt",  {16'd0, frame_cnt}, 32'd0);
        check("rst.pulses", {28'd0, frame_done, sel_err, seg_err, order_err}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Latency: held from E0, visible after E3 and not before
        s0 = c_sel; g0 = c_seg; f0 = c_frm; o0 = c_ord;
        sel_n = 8'hFE; seg_n = 8'hC0;
        repeat (3) @(negedge clk);
        check("lat.early_valid", {24'd0, digit_valid}, 32'd0);
        @(negedge clk);
        check("lat.bcd0",  {28'd0, digit_bcd[3:0]}, 32'd0);
        check("lat.valid", {24'd0, digit_valid}, 32'h01);
        check("lat.dp",    {24'd0, dp}, 32'd0);
        check_pulses("lat", s0, g0, f0, o0, 0, 0, 0, 0);

        for (int k = 0; k < split; k++) run_row(k);

        // Glitch inside a 6-cycle dwell: only the final stable value is sampled
        s0 = c_sel; g0 = c_seg; f0 = c_frm; o0 = c_ord;
        @(negedge clk);
        sel_n = 8'hFD; seg_n = 8'hB0;
        @(negedge clk);
        seg_n = 8'hFF;
        @(negedge clk);
        seg_n = 8'hB0;
        repeat (4) @(negedge clk);
        check("glitch.bcd",   digit_bcd, 32'h87654F31);
        check("glitch.valid", {24'd0, digit_valid}, 32'h000000FB);
        check_pulses("glitch", s0, g0, f0, o0, 0, 0, 0, 0);

        for (int k = split; k < tv.size(); k++) run_row(k);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
